lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
Load/store unit for the MEM stage of the RISC-V core. It consumes the memory controls produced by the main decoder: mem_w = {funct3, store_en}, and result_src == 2'b01 marks a load. It takes the ALU-computed address and rs2 data, and runs a req/gnt/rvalid transaction on the data-memory bus. It returns sign- or zero-extended load data to writeback and stalls the pipeline while a transaction is outstanding.

Parameters:
TIMEOUT, 255, bus cycles allowed in REQ+WAIT before aborting with err; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
op_valid  input  1  MEM-stage instruction valid
mem_w  input  4  {funct3[2:0], store_en}
mem_rd  input  1  load request (decoder result_src == 2'b01)
addr  input  32  byte address from ALU
wdata  input  32  store data (rs2)
stall  output  1  hold upstream stages
done  output  1  one-cycle pulse: access completed
load_valid  output  1  one-cycle pulse: load_data valid (load only)
load_data  output  32  extended load result
misalign  output  1  combinational: misaligned access rejected
err  output  1  one-cycle pulse: illegal funct3, mem_rd and store_en both set, or timeout
dmem_req  output  1  bus request
dmem_we  output  1  bus write enable
dmem_addr  output  32  word address, {addr[31:2], 2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_gnt  input  1  request accepted
dmem_rvalid  input  1  read data valid
dmem_rdata  input  32  read data

Behaviour:
- Single clock domain clk. rst is synchronous and active-high.
- Reset values:
  - state = IDLE; counter = 0.
  - All outputs are 0, including load_data and all dmem_* signals.
  - rst asserted mid-transaction: return to IDLE on that edge. dmem_req is 0 the next cycle. No done, load_valid or err is produced.
- States: IDLE, REQ, WAIT, RESP.
- A request is accepted when all of the following hold:
  - state is IDLE or RESP;
  - op_valid && (mem_rd ^ mem_w[0]);
  - funct3 is legal;
  - the address is aligned.
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000, 001, 010.
- Misalignment:
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0.
- Misaligned request: misalign = 1 combinationally in that cycle. The request is not accepted, stall = 0, and no bus activity occurs.
- Illegal funct3, or mem_rd && mem_w[0]: no bus activity; err pulses in the next cycle.
- On accept, register the bus fields and go to REQ:
  - dmem_we = store_en;
  - dmem_addr = {addr[31:2], 2'b00};
  - dmem_be:
    - byte: 4'b0001 << addr[1:0];
    - half: 4'b0011 << addr[1:0];
    - word: 4'b1111;
  - dmem_wdata:
    - byte: {4{wdata[7:0]}};
    - half: {2{wdata[15:0]}};
    - word: wdata;
  - capture funct3 and addr[1:0] for extraction.
- REQ:
  - dmem_req = 1; all dmem_* outputs held stable until dmem_gnt.
  - On gnt with a store: go to RESP.
  - On gnt with a load: go to WAIT.
  - dmem_req drops in the cycle after gnt.
- WAIT:
  - On dmem_rvalid: select the lane by the captured offset, extend it (sign-extend for LB/LH, zero-extend for LBU/LHU), register it into load_data, and go to RESP.
  - rvalid outside WAIT is ignored. rvalid never arrives in the same cycle as gnt.
- RESP:
  - done = 1 for exactly one cycle.
  - load_valid = 1 only for loads.
  - load_data is held until the next load completes.
  - RESP can accept a new request back-to-back; otherwise go to IDLE.
- stall = (state == REQ || state == WAIT) || (accept in this cycle). stall is 0 in RESP unless a new request is accepted.
- Timeout:
  - The counter clears on accept and increments each cycle in REQ or WAIT.
  - When TIMEOUT != 0 and counter == TIMEOUT - 1 without progress: go to IDLE, pulse err next cycle, drop dmem_req, and give no done.
- Minimum latency with gnt held high:
  - store: accept at cycle 0, req at 1, done at 2;
  - load with rvalid one cycle after gnt: load_valid at 3.

Test Plan:
- Accept SW with addr = 0x104, wdata = 0xDEADBEEF, gnt = 1 -> cycle 1: dmem_req = 1, dmem_we = 1, dmem_addr = 0x104, be = 4'b1111; cycle 2: done = 1; stall high during cycles 0-1 only.
- Accept LB with addr = 0x203, rdata = 0x80FF_1234 -> be = 4'b1000, load_data = 0xFFFFFF80. Same with LBU -> 0x00000080. LHU at addr = 0x202 -> 0x000080FF.
- SH with addr = 0x11, wdata = 0x0000ABCD -> misalign = 1 in that cycle, stall = 0, dmem_req stays 0. LW with addr = 0x2 -> misalign = 1.
- gnt withheld 5 cycles on SB with addr = 0x1, wdata = 0x5A -> dmem_addr = 0x0, be = 4'b0010, wdata = 0x5A5A5A5A stable for all 6 request cycles; done 1 cycle after gnt.
- TIMEOUT = 4, gnt never asserted -> err pulses 1 cycle after the 4th request cycle, dmem_req = 0, state IDLE, done never asserts.
- rst asserted while in WAIT, then rvalid arrives -> no load_valid, load_data = 0. Back-to-back LW / SW accepted in RESP -> two done pulses with no idle gap.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit.
// Runs req/gnt/rvalid bus accesses, extends loads, stalls the pipe.
module lsu_mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  mem_w,
  input  logic        mem_rd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TLAST);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;
  logic             r_done;
  logic             r_lvalid;
  logic [31:0]      r_ldata;
  logic             r_err;

  logic [2:0]  w_f3;
  logic        w_st;
  logic        w_can;
  logic        w_req;
  logic        w_legal;
  logic        w_mis;
  logic        w_acc;
  logic        w_bad;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;

  assign w_f3  = mem_w[3:1];
  assign w_st  = mem_w[0];
  assign w_can = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_req = op_valid && (mem_rd ^ w_st);

  // funct3 legality: unsigned variants exist only for loads
  always_comb begin
    w_legal = 1'b0;
    unique case (w_f3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = mem_rd;
      default:                w_legal = 1'b0;
    endcase
  end

  // natural alignment by access size
  always_comb begin
    w_mis = 1'b0;
    unique case (w_f3[1:0])
      2'b01:   w_mis = addr[0];
      2'b10:   w_mis = |addr[1:0];
      default: w_mis = 1'b0;
    endcase
  end

  assign w_acc = w_can && w_req && w_legal && !w_mis;
  assign w_bad = w_can && op_valid &&
                 ((mem_rd && w_st) || (w_req && !w_legal));
  assign w_tmo = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // byte enables and lane-replicated store data
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    unique case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << addr[1:0];
        w_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = dmem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = dmem_rdata[{r_off[1], 4'b0000} +: 16];

  // lane select and sign/zero extension of returned data
  always_comb begin
    w_ldata = dmem_rdata;
    unique case (r_f3)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b100:  w_ldata = {24'd0, w_byte};
      3'b101:  w_ldata = {16'd0, w_half};
      default: ;
    endcase
  end

  // bus transaction FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_f3     <= '0;
      r_off    <= '0;
      r_done   <= 1'b0;
      r_lvalid <= 1'b0;
      r_ldata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_lvalid <= 1'b0;
      r_err    <= w_bad;
      unique case (r_state)
        S_IDLE, S_RESP: begin
          if (w_acc) begin
            r_state <= S_REQ;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= w_st;
            r_addr  <= {addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_f3    <= w_f3;
            r_off   <= addr[1:0];
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            r_req   <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= r_we ? S_RESP : S_WAIT;
            r_done  <= r_we;
          end else if (w_tmo) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            r_state  <= S_RESP;
            r_ldata  <= w_ldata;
            r_done   <= 1'b1;
            r_lvalid <= 1'b1;
          end else if (w_tmo) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall      = (r_state == S_REQ) || (r_state == S_WAIT) || w_acc;
  assign misalign   = w_can && w_req && w_legal && w_mis;
  assign done       = r_done;
  assign load_valid = r_lvalid;
  assign load_data  = r_ldata;
  assign err        = r_err;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed plus random accesses for lsu_mem_stage.
// Expected values come from a transaction-level arithmetic model.
module tb_lsu_mem_stage;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  mem_w;
  logic        mem_rd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign;
  logic        err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [31:0] m_ldata;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .mem_w(mem_w),
    .mem_rd(mem_rd), .addr(addr), .wdata(wdata), .stall(stall),
    .done(done), .load_valid(load_valid), .load_data(load_data),
    .misalign(misalign), .err(err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_in();
    op_valid    = 1'b0;
    mem_rd      = 1'b0;
    mem_w       = 4'd0;
    addr        = $urandom;
    wdata       = $urandom;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = $urandom;
  endtask

  task automatic drive(input bit ld, input logic [2:0] f3, input bit both,
                       input logic [31:0] a, input logic [31:0] wd);
    op_valid = 1'b1;
    mem_rd   = ld || both;
    mem_w    = {f3, (!ld) || both};
    addr     = a;
    wdata    = wd;
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3,
                                              input int off,
                                              input logic [31:0] rd);
    logic [31:0] s;
    logic [31:0] v;
    s = rd >> (8 * off);
    case (f3)
      3'd0: begin
        v = s & 32'hFF;
        if (v >= 128) v = v - 256;
      end
      3'd1: begin
        v = s & 32'hFFFF;
        if (v >= 32768) v = v - 65536;
      end
      3'd4: v = s & 32'hFF;
      3'd5: v = s & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  // one whole access from presentation to the idle cycle after it
  task automatic run_op(input bit ld, input logic [2:0] f3, input bit both,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int gd,
                        input int rdl);
    bit legal, bad, alig, acc, mis;
    int n, off;
    logic [31:0] ebe, ewd, eaddr;
    logic [7:0]  w8;
    logic [15:0] w16;
    if (ld) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else    legal = f3 inside {3'd0, 3'd1, 3'd2};
    bad   = both || !legal;
    n     = 1 << f3[1:0];
    off   = int'(a % 4);
    alig  = (a % n) == 0;
    acc   = !bad && alig;
    mis   = !bad && !alig;
    ebe   = ((32'd1 << n) - 1) << off;
    w8    = wd[7:0];
    w16   = wd[15:0];
    ewd   = (n == 1) ? w8 * 32'h01010101 :
            (n == 2) ? w16 * 32'h00010001 : wd;
    eaddr = a - (a % 4);
    drive(ld, f3, both, a, wd);
    mid();
    if (!bad) chk("misalign", misalign, mis);
    chk("stall_accept", stall, acc);
    cyc();
    idle_in();
    if (!acc) begin
      mid();
      chk("err_reject", err, bad);
      chk("req_reject", dmem_req, 1'b0);
      chk("done_reject", done, 1'b0);
      cyc();
      return;
    end
    for (int k = 0; k <= gd; k++) begin
      dmem_gnt = (k == gd);
      mid();
      chk("req_hold", dmem_req, 1'b1);
      chk("we", dmem_we, !ld);
      chk("addr", dmem_addr, eaddr);
      chk("be", dmem_be, ebe);
      if (!ld) chk("wdata", dmem_wdata, ewd);
      chk("stall_req", stall, 1'b1);
      cyc();
    end
    dmem_gnt = 1'b0;
    if (ld) begin
      for (int k = 1; k <= rdl; k++) begin
        dmem_rvalid = (k == rdl);
        dmem_rdata  = (k == rdl) ? rd : $urandom;
        mid();
        chk("req_wait", dmem_req, 1'b0);
        chk("stall_wait", stall, 1'b1);
        chk("done_wait", done, 1'b0);
        cyc();
      end
      dmem_rvalid = 1'b0;
      m_ldata = model_load(f3, off, rd);
    end
    mid();
    chk("done", done, 1'b1);
    chk("load_valid", load_valid, ld);
    chk("load_data", load_data, m_ldata);
    chk("stall_resp", stall, 1'b0);
    chk("err_resp", err, 1'b0);
    cyc();
    mid();
    chk("done_after", done, 1'b0);
    chk("lv_after", load_valid, 1'b0);
    cyc();
  endtask

  initial begin
    bit ld, both;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] lds [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b1;
    idle_in();
    m_ldata = 32'd0;
    cyc();
    cyc();
    mid();
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_lv", load_valid, 1'b0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", dmem_be, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    run_op(0, 3'd2, 0, 32'h104, 32'hDEADBEEF, 0, 0, 1);
    run_op(1, 3'd0, 0, 32'h203, 0, 32'h80FF1234, 0, 1);
    chk("lb_value", m_ldata, 32'hFFFFFF80);
    run_op(1, 3'd4, 0, 32'h203, 0, 32'h80FF1234, 0, 1);
    run_op(1, 3'd5, 0, 32'h202, 0, 32'h80FF1234, 1, 2);
    run_op(0, 3'd1, 0, 32'h11, 32'h0000ABCD, 0, 0, 1);
    run_op(1, 3'd2, 0, 32'h2, 0, 0, 0, 1);
    run_op(0, 3'd0, 0, 32'h1, 32'h5A, 0, 5, 1);
    run_op(1, 3'd3, 0, 32'h40, 0, 0, 0, 1);
    run_op(0, 3'd4, 0, 32'h40, 32'h1, 0, 0, 1);
    run_op(1, 3'd2, 1, 32'h40, 32'h1, 0, 0, 1);

    // timeout: gnt never arrives
    drive(0, 3'd2, 0, 32'h40, 32'h77);
    mid();
    chk("to_stall0", stall, 1'b1);
    cyc();
    idle_in();
    for (int k = 0; k < TO; k++) begin
      mid();
      chk("to_req", dmem_req, 1'b1);
      chk("to_err_early", err, 1'b0);
      cyc();
    end
    mid();
    chk("to_req_drop", dmem_req, 1'b0);
    chk("to_err", err, 1'b1);
    chk("to_done", done, 1'b0);
    chk("to_stall", stall, 1'b0);
    cyc();
    mid();
    chk("to_err_pulse", err, 1'b0);
    chk("to_done2", done, 1'b0);
    cyc();

    // reset while in REQ
    drive(0, 3'd2, 0, 32'h50, 32'h1);
    cyc();
    idle_in();
    rst = 1'b1;
    mid();
    chk("rreq_req", dmem_req, 1'b1);
    cyc();
    rst = 1'b0;
    mid();
    chk("rreq_req_off", dmem_req, 1'b0);
    chk("rreq_done", done, 1'b0);
    chk("rreq_err", err, 1'b0);
    cyc();

    // reset while in WAIT, then a stray rvalid
    drive(1, 3'd2, 0, 32'h300, 32'h0);
    cyc();
    idle_in();
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt = 1'b0;
    rst = 1'b1;
    mid();
    chk("rwait_stall", stall, 1'b1);
    cyc();
    rst = 1'b0;
    m_ldata = 32'd0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12345678;
    mid();
    chk("rwait_req", dmem_req, 1'b0);
    chk("rwait_stall2", stall, 1'b0);
    cyc();
    dmem_rvalid = 1'b0;
    mid();
    chk("rwait_lv", load_valid, 1'b0);
    chk("rwait_ldata", load_data, 32'd0);
    chk("rwait_done", done, 1'b0);
    chk("rwait_err", err, 1'b0);
    cyc();

    // back-to-back LW then SW accepted in RESP
    drive(1, 3'd2, 0, 32'h80, 32'h0);
    cyc();
    idle_in();
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    cyc();
    dmem_rvalid = 1'b0;
    m_ldata = 32'hCAFEF00D;
    drive(0, 3'd2, 0, 32'h84, 32'h11223344);
    mid();
    chk("b2b_done1", done, 1'b1);
    chk("b2b_lv1", load_valid, 1'b1);
    chk("b2b_ldata1", load_data, m_ldata);
    chk("b2b_stall", stall, 1'b1);
    cyc();
    idle_in();
    dmem_gnt = 1'b1;
    mid();
    chk("b2b_req", dmem_req, 1'b1);
    chk("b2b_we", dmem_we, 1'b1);
    chk("b2b_addr", dmem_addr, 32'h84);
    chk("b2b_wdata", dmem_wdata, 32'h11223344);
    chk("b2b_nodone", done, 1'b0);
    cyc();
    dmem_gnt = 1'b0;
    mid();
    chk("b2b_done2", done, 1'b1);
    chk("b2b_lv2", load_valid, 1'b0);
    chk("b2b_ldata2", load_data, m_ldata);
    cyc();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0BADBAD0;
    mid();
    chk("b2b_idle", done, 1'b0);
    cyc();
    dmem_rvalid = 1'b0;
    mid();
    chk("stray_rvalid", load_data, m_ldata);
    chk("stray_lv", load_valid, 1'b0);
    cyc();

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      ld   = bit'($urandom % 2);
      both = ($urandom % 16) == 0;
      if (($urandom % 4) != 0) f3 = lds[$urandom % (ld ? 5 : 3)];
      else                     f3 = 3'($urandom % 8);
      a = $urandom;
      if (($urandom % 3) != 0) a[1:0] = 2'b00;
      run_op(ld, f3, both, a, $urandom, $urandom,
             int'($urandom % 3), 1 + int'($urandom % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
